tx_frame_ctrl: RTL
==================

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame (legal 5..9).
REQ-002 SHALL have port Clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port ResetN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port BaudTick  input  1  one-Clock pulse marking each bit-period boundary.
REQ-005 SHALL have port Send  input  1  frame request, level-sampled in IDLE.
REQ-006 SHALL have port DataIn  input  DATA_WIDTH  frame payload.
REQ-007 SHALL have port ParityType  input  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port StopBits  input  1  stop-bit count: 0 one stop bit, 1 two stop bits.
REQ-009 SHALL have port TxOut  output  1  serial line, idle high.
REQ-010 SHALL have port Busy  output  1  high from request capture until frame end.
REQ-011 SHALL have port Done  output  1  one-Clock pulse at frame end.
REQ-012 SHALL have port ParityOut  output  1  parity bit computed for the latched frame.

Function
REQ-013 SHALL implement the states IDLE, ARM, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-014 In IDLE with Send=1 on a Clock edge, the block SHALL latch DataIn, ParityType and StopBits, enter ARM and set Busy=1 on the same edge, independent of BaudTick.
REQ-015 ParityOut SHALL be latched at capture: XOR of DataIn for even, inverted XOR for odd, 0 for modes 00/11.
REQ-016 In ARM, the next BaudTick SHALL move to START, with TxOut=0 from that edge.
REQ-017 Each subsequent BaudTick SHALL advance exactly one bit; TxOut SHALL never change except on a BaudTick edge or reset.
REQ-018 DATA SHALL send latched bits LSB first over DATA_WIDTH periods, using a bit counter of width ceil(log2(DATA_WIDTH)) that clears on entry to DATA.
REQ-019 After the last data bit, the block SHALL go to PARITY (TxOut=ParityOut) for modes 01/10, or directly to STOP for 00/11.
REQ-020 STOP SHALL drive TxOut=1 for 1 or 2 periods per the latched StopBits.
REQ-021 The BaudTick ending the last stop bit SHALL return the block to IDLE, set Busy=0 and pulse Done=1 for exactly one Clock.
REQ-022 Frame length from the START edge to the Done edge SHALL be 1+DATA_WIDTH+P+S BaudTicks, where P is 0 or 1 and S is 1 or 2.
REQ-023 Send while Busy=1 SHALL be ignored, with no queuing.
REQ-024 Send=1 in the IDLE cycle immediately after Done SHALL be captured, giving back-to-back frames with no extra idle period beyond ARM.
REQ-025 Changes to DataIn, ParityType or StopBits while Busy=1 SHALL NOT affect the frame in flight.
REQ-026 BaudTick in IDLE SHALL have no effect.
REQ-027 A BaudTick coincident with the capture edge SHALL NOT advance ARM; ARM waits for the next BaudTick.
REQ-028 The bit counter SHALL saturate and never wrap into a second data pass.

Reset
REQ-029 When ResetN=0, the block SHALL immediately force state=IDLE, TxOut=1, Busy=0, Done=0, ParityOut=0, and clear the bit counter and latched registers.
REQ-030 Reset asserted mid-frame SHALL abort the frame, with no Done pulse and TxOut=1 at once; the first capture after release SHALL behave as from cold reset.

Verification
REQ-031 The bench SHALL cover: DataIn=0x07, ParityType=10, StopBits=0 -> TxOut per tick 0,1,1,1,0,0,0,0,0,1,1; ParityOut=1; Done after 11 ticks.
REQ-032 The bench SHALL cover: DataIn=0x07, ParityType=01 -> ParityOut=0 and parity slot 0; DataIn=0x0F, ParityType=00 -> no parity slot, Done after 10 ticks.
REQ-033 The bench SHALL cover: StopBits=1, ParityType=11, DataIn=0xAF -> TxOut 0,1,1,1,1,0,1,0,1,1,1; Done after 11 ticks; Busy high throughout.
REQ-034 The bench SHALL cover: Send held high continuously -> second frame's ARM follows Done by one Clock; a second Send mid-frame is ignored; DataIn changed mid-frame does not alter serial bits.
REQ-035 The bench SHALL cover: ResetN pulled low during data bit 4 -> TxOut=1 and Busy=0 asynchronously, no Done; the next Send transmits a full correct frame.
REQ-036 The bench SHALL cover: BaudTick asserted on the same edge as the Send capture -> START begins on the following BaudTick, not that one.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// Serial frame transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional odd/even parity bit and one or two stop bits, paced by BaudTick.
module tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  BaudTick,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [1:0]            ParityType,
    input  logic                  StopBits,
    output logic                  TxOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  ParityOut
);

    localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            ptype_q, ptype_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  par_q, par_d;
    logic                  par_en;

    // Modes 01 and 10 insert a parity slot; 00 and 11 do not.
    assign par_en = ptype_q[0] ^ ptype_q[1];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            ptype_q    <= 2'b00;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            ptype_q    <= ptype_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            par_q      <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        ptype_d    = ptype_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        par_d      = par_q;

        case (state_q)
            ST_IDLE: begin
                if (Send) begin
                    shift_d    = DataIn;
                    ptype_d    = ParityType;
                    stop2_d    = StopBits;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_ARM;
                    case (ParityType)
                        2'b01:   par_d = ~^DataIn;
                        2'b10:   par_d = ^DataIn;
                        default: par_d = 1'b0;
                    endcase
                end
            end
            ST_ARM: begin
                if (BaudTick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (BaudTick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // The counter stops at LAST_BIT, so it can never roll into a second pass.
                if (BaudTick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (BaudTick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (BaudTick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign TxOut     = tx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ParityOut = par_q;

endmodule
